fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high; clock clk.
REQ-003 SHALL have: if_rst, id_rst  input  1 each  stage resets from pipeline controller, synchronous.
REQ-004 SHALL have: if_en, id_en  input  1 each  stage enables from pipeline controller.
REQ-005 SHALL have: pc_src  input  3  next-PC select for instruction in ID; 0=NEXT, 1=JUMP, 2=JR, 3=BRANCH, 4-7 treated as NEXT.
REQ-006 SHALL have: rs_data  input  32  forwarded rs value for the instruction in ID (JR target).
REQ-007 SHALL have: imem_req  output  1;  imem_addr  output  32;  imem_ack  input  1;  imem_rdata  input  32  instruction memory port.
REQ-008 SHALL have: inst_id  output  32;  pc_id  output  32;  id_valid  output  1  IF/ID register contents.
REQ-009 SHALL have: if_valid  output  1  fetched word available in IF this cycle;  fetch_stall  output  1  IF waiting on memory.

Function
REQ-010 SHALL hold PC register (32 bit), reset vector 0x00000000.
REQ-011 SHALL implement FSM states REQ (request outstanding) and BUF (word held, waiting for enable).
REQ-012 In REQ: imem_req=1, imem_addr={pc[31:2],2'b00}; in BUF: imem_req=0.
REQ-013 advance = if_en & id_en & ((REQ & imem_ack) | BUF).
REQ-014 REQ & imem_ack & ~advance: SHALL latch imem_rdata into inst_buf, go BUF; rdata ignored in BUF.
REQ-015 On advance: IF/ID SHALL load word (imem_rdata from REQ, inst_buf from BUF), pc_id<=pc, id_valid<=1; FSM->REQ.
REQ-016 id_en=1 & ~advance: IF/ID SHALL load bubble: inst_id<=0, id_valid<=0, pc_id unchanged.
REQ-017 id_en=0: IF/ID SHALL hold all contents.
REQ-018 Targets from ID: link=pc_id+4; JUMP={link[31:28],inst_id[25:0],2'b00}; BRANCH=link+(sext(inst_id[15:0])<<2), 32-bit wrap; JR=rs_data.
REQ-019 redirect_req = id_valid & pc_src in {1,2,3}; delay-slot semantics: word in IF when branch is in ID SHALL always issue.
REQ-020 On advance: pc<=target if redirect_req; else redirect_pc if redirect_pending (then clear); else pc+4 (wrap at 2^32).
REQ-021 redirect_req & id_en & ~advance: SHALL latch target into redirect_pc, set redirect_pending (branch leaves ID before delay slot fetched).
REQ-022 redirect_req & id_en=0: SHALL not latch; re-evaluated next cycle with current rs_data.
REQ-023 Redirect applied to PC after the delay-slot word advances, never earlier, never twice.
REQ-024 if_valid = (REQ & imem_ack) | BUF; fetch_stall = REQ & ~imem_ack.
REQ-025 Unaligned JR target: low 2 bits kept in pc, masked on imem_addr only.

Reset
REQ-026 rst or if_rst: pc<=0, FSM<=REQ, redirect_pending<=0, inst_buf<=0; precedence over advance.
REQ-027 rst or id_rst: inst_id<=0, pc_id<=0, id_valid<=0; precedence over id_en.
REQ-028 if_rst mid-request: an ack arriving in the reset cycle SHALL be discarded; new request to 0x0 next cycle.
REQ-029 First imem_req SHALL assert in the cycle after rst deasserts, addr 0x0.

Verification
REQ-030 Zero-wait memory, pc_src=0, enables high: imem_addr 0x0,0x4,0x8 on consecutive cycles; inst_id follows one cycle later, id_valid=1.
REQ-031 Branch in ID: inst_id=0x1000_0003, pc_id=0x10, pc_src=3, ack same cycle -> delay slot 0x14 enters ID, next imem_addr=0x20.
REQ-032 JR with pc_src=2, rs_data=0x400, imem_ack low 3 cycles -> bubbles into ID, redirect_pending=1; after ack delay slot issues, next imem_addr=0x400.
REQ-033 Load stall: ack with if_en=id_en=0 for 2 cycles -> FSM BUF, imem_req=0, inst_id held; on release buffered word enters ID, request pc+4.
REQ-034 rst pulse while REQ pending at 0x40 with ack in rst cycle -> word discarded, id_valid=0, next imem_addr=0x0.
REQ-035 JUMP inst_id=0x0800_0100 at pc_id=0xF000_0008 -> target 0xF000_0400 after delay slot.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-request imem FSM, IF/ID register and delay-slot redirect.
// A fetched word is buffered when the pipeline is stalled; redirects wait for the delay-slot word to advance.
module fetch_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_rst,
   input  logic        id_rst,
   input  logic        if_en,
   input  logic        id_en,
   input  logic [2:0]  pc_src,
   input  logic [31:0] rs_data,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_id,
   output logic [31:0] pc_id,
   output logic        id_valid,
   output logic        if_valid,
   output logic        fetch_stall
);

   typedef enum logic {S_REQ, S_BUF} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_buf_q, inst_buf_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        redirect_pending_q, redirect_pending_d;
   logic [31:0] inst_id_q, inst_id_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic        id_valid_q, id_valid_d;

   logic        if_clr, id_clr, word_rdy, advance, redirect_req;
   logic [31:0] link, target, fetch_word;

   always_comb begin
      if_clr     = rst | if_rst;
      id_clr     = rst | id_rst;
      word_rdy   = ((state_q == S_REQ) & imem_ack) | (state_q == S_BUF);
      // An ack landing in an IF reset cycle is discarded, so it must not advance either.
      advance    = if_en & id_en & word_rdy & ~if_clr;
      fetch_word = (state_q == S_BUF) ? inst_buf_q : imem_rdata;
      link       = pc_id_q + 32'd4;
      case (pc_src)
         3'd1:    target = {link[31:28], inst_id_q[25:0], 2'b00};
         3'd2:    target = rs_data;
         3'd3:    target = link + {{14{inst_id_q[15]}}, inst_id_q[15:0], 2'b00};
         default: target = link;
      endcase
      redirect_req = id_valid_q & ((pc_src == 3'd1) | (pc_src == 3'd2) | (pc_src == 3'd3));
   end

   assign imem_req    = (state_q == S_REQ) & ~rst;
   assign imem_addr   = {pc_q[31:2], 2'b00};
   assign if_valid    = word_rdy;
   assign fetch_stall = (state_q == S_REQ) & ~imem_ack;
   assign inst_id     = inst_id_q;
   assign pc_id       = pc_id_q;
   assign id_valid    = id_valid_q;

   always_comb begin
      state_d            = state_q;
      pc_d               = pc_q;
      inst_buf_d         = inst_buf_q;
      redirect_pc_d      = redirect_pc_q;
      redirect_pending_d = redirect_pending_q;
      if (if_clr) begin
         state_d            = S_REQ;
         pc_d               = 32'd0;
         inst_buf_d         = 32'd0;
         redirect_pc_d      = 32'd0;
         redirect_pending_d = 1'b0;
      end else if (advance) begin
         state_d            = S_REQ;
         redirect_pending_d = 1'b0;
         if (redirect_req)
            pc_d = target;
         else if (redirect_pending_q)
            pc_d = redirect_pc_q;
         else
            pc_d = pc_q + 32'd4;
      end else begin
         if ((state_q == S_REQ) && imem_ack) begin
            inst_buf_d = imem_rdata;
            state_d    = S_BUF;
         end
         // Branch leaves ID before its delay slot is fetched: remember where to go.
         if (redirect_req && id_en) begin
            redirect_pc_d      = target;
            redirect_pending_d = 1'b1;
         end
      end
   end

   always_comb begin
      inst_id_d  = inst_id_q;
      pc_id_d    = pc_id_q;
      id_valid_d = id_valid_q;
      if (id_clr) begin
         inst_id_d  = 32'd0;
         pc_id_d    = 32'd0;
         id_valid_d = 1'b0;
      end else if (id_en) begin
         if (advance) begin
            inst_id_d  = fetch_word;
            pc_id_d    = pc_q;
            id_valid_d = 1'b1;
         end else begin
            inst_id_d  = 32'd0;
            id_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      inst_buf_q         <= inst_buf_d;
      redirect_pc_q      <= redirect_pc_d;
      redirect_pending_q <= redirect_pending_d;
      inst_id_q          <= inst_id_d;
      pc_id_q            <= pc_id_d;
      id_valid_q         <= id_valid_d;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed pipeline scenarios with a fetch-address and IF/ID scoreboard.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst, if_rst, id_rst, if_en, id_en;
   logic [2:0]  pc_src;
   logic [31:0] rs_data;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] inst_id, pc_id;
   logic        id_valid, if_valid, fetch_stall;

   logic        ack_en;
   logic        corrupt;
   logic        ld_ok = 1'b0;
   int          total = 0;
   int          bad   = 0;

   logic [31:0] addr_q[$];
   logic [63:0] id_q[$];

   fetch_stage dut (
      .clk(clk), .rst(rst), .if_rst(if_rst), .id_rst(id_rst),
      .if_en(if_en), .id_en(id_en), .pc_src(pc_src), .rs_data(rs_data),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_id(inst_id), .pc_id(pc_id), .id_valid(id_valid),
      .if_valid(if_valid), .fetch_stall(fetch_stall)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0010: return 32'h1000_0003;
         32'hF000_0008: return 32'h0800_0100;
         default:       return ~a;
      endcase
   endfunction

   always_comb begin
      imem_ack   = ack_en;
      imem_rdata = corrupt ? 32'hDEAD_BEEF : mem_word(imem_addr);
   end

   always @(posedge clk) ld_ok <= id_en && !rst && !id_rst;

   // Scoreboard monitor: accepted fetch handshakes and IF/ID loads are popped in order.
   always @(negedge clk) begin
      if (imem_req && imem_ack && !rst && !if_rst) begin
         total += 1;
         if (addr_q.size() == 0) begin
            bad += 1;
            $display("FAIL fetch_addr unexpected fetch got=%h", imem_addr);
         end else begin
            logic [31:0] ea;
            ea = addr_q.pop_front();
            if (imem_addr !== ea) begin
               bad += 1;
               $display("FAIL fetch_addr got=%h exp=%h", imem_addr, ea);
            end
         end
      end
      if (ld_ok && id_valid) begin
         total += 1;
         if (id_q.size() == 0) begin
            bad += 1;
            $display("FAIL id_load unexpected pc_id=%h inst_id=%h", pc_id, inst_id);
         end else begin
            logic [63:0] ei;
            ei = id_q.pop_front();
            if ({pc_id, inst_id} !== ei) begin
               bad += 1;
               $display("FAIL id_load got pc=%h inst=%h exp pc=%h inst=%h",
                        pc_id, inst_id, ei[63:32], ei[31:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total += 1;
      if (got !== exp) begin
         bad += 1;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_id(input logic [31:0] pc, input logic [31:0] word_addr);
      id_q.push_back({pc, mem_word(word_addr)});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; if_rst = 1'b0; id_rst = 1'b0; if_en = 1'b1; id_en = 1'b1;
      pc_src = 3'd0; rs_data = 32'd0; ack_en = 1'b1; corrupt = 1'b0;

      // Fetch addresses in acceptance order.
      foreach (addr_q[i]) addr_q.delete(i);
      addr_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20,
                 32'h24, 32'h400, 32'h404, 32'h408,
                 32'hF000_0008, 32'hF000_000C, 32'hF000_0400, 32'hF000_0404,
                 32'h00, 32'h04, 32'h00, 32'h04, 32'h08};
      // IF/ID loads: pc_id and the word fetched from that (aligned) address.
      push_id(32'h00, 32'h00); push_id(32'h04, 32'h04); push_id(32'h08, 32'h08);
      push_id(32'h0C, 32'h0C); push_id(32'h10, 32'h10); push_id(32'h14, 32'h14);
      push_id(32'h20, 32'h20); push_id(32'h24, 32'h24); push_id(32'h400, 32'h400);
      push_id(32'h404, 32'h404); push_id(32'h408, 32'h408);
      push_id(32'hF000_000A, 32'hF000_0008); push_id(32'hF000_000E, 32'hF000_000C);
      push_id(32'hF000_0400, 32'hF000_0400); push_id(32'hF000_0404, 32'hF000_0404);
      push_id(32'h00, 32'h00); push_id(32'h04, 32'h04);
      push_id(32'h00, 32'h00); push_id(32'h04, 32'h04); push_id(32'h08, 32'h08);

      repeat (3) step();
      @(negedge clk);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_id_valid", {31'd0, id_valid}, 32'd0);
      check("rst_inst_id", inst_id, 32'd0);
      check("rst_pc_id", pc_id, 32'd0);
      step();
      rst = 1'b0;                                   // cycle 0
      repeat (5) step();
      pc_src = 3'd3;                                // c5: branch at 0x10 in ID
      step();
      pc_src = 3'd0;                                // c6: delay slot 0x14 in ID
      step();
      pc_src = 3'd2; rs_data = 32'h400; ack_en = 1'b0;  // c7: JR, memory slow
      @(negedge clk);
      check("stall_fetch_stall", {31'd0, fetch_stall}, 32'd1);
      check("stall_if_valid", {31'd0, if_valid}, 32'd0);
      step();
      pc_src = 3'd0;                                // c8
      @(negedge clk);
      check("bubble_id_valid", {31'd0, id_valid}, 32'd0);
      check("bubble_inst_id", inst_id, 32'd0);
      check("bubble_pc_id_held", pc_id, 32'h20);
      step();                                       // c9
      step();
      ack_en = 1'b1;                                // c10: delay slot 0x24 issues
      step();                                       // c11
      step();
      if_en = 1'b0; id_en = 1'b0;                   // c12: load stall
      @(negedge clk);
      check("ls_if_valid_req", {31'd0, if_valid}, 32'd1);
      step();
      corrupt = 1'b1;                               // c13: BUF, rdata must be ignored
      @(negedge clk);
      check("buf_imem_req", {31'd0, imem_req}, 32'd0);
      check("buf_if_valid", {31'd0, if_valid}, 32'd1);
      check("buf_inst_id_held", inst_id, mem_word(32'h400));
      check("buf_pc_id_held", pc_id, 32'h400);
      step();
      if_en = 1'b1; id_en = 1'b1;                   // c14: buffered word released
      step();
      corrupt = 1'b0; pc_src = 3'd2; rs_data = 32'hF000_000A;  // c15: unaligned JR
      step();
      pc_src = 3'd0;                                // c16
      step();
      pc_src = 3'd1;                                // c17: JUMP at pc_id 0xF000_000A
      step();
      pc_src = 3'd0;                                // c18
      step();
      pc_src = 3'd2; rs_data = 32'h40;              // c19: JR to 0x40
      step();
      pc_src = 3'd0; ack_en = 1'b0;                 // c20: request at 0x40 pending
      step();
      rst = 1'b1; ack_en = 1'b1;                    // c21: ack during reset
      step();
      rst = 1'b0;                                   // c22
      @(negedge clk);
      check("post_rst_id_valid", {31'd0, id_valid}, 32'd0);
      check("post_rst_imem_req", {31'd0, imem_req}, 32'd1);
      step();                                       // c23
      step();
      if_rst = 1'b1;                                // c24: IF reset mid-request
      step();
      if_rst = 1'b0;                                // c25
      step();                                       // c26
      step();                                       // c27
      step();
      ack_en = 1'b0;                                // c28
      repeat (3) step();
      check("addr_q_drained", addr_q.size(), 32'd0);
      check("id_q_drained", id_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
